// File: rtl/blk_sync.sv
// Block-grid video synchroniser: masks de_i to a HBLKS*BLKW x VBLKS*BLKH window
// and issues per-block-column and per-block-row save strobes.
module blk_sync #(
  parameter int HBLKS = 10,
  parameter int VBLKS = 10,
  parameter int BLKW  = 30,
  parameter int BLKH  = 30
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [23:0] rgb_i,
  output logic        de_o,
  output logic [23:0] wd_o,
  output logic        h_save_o,
  output logic        v_save_o,
  output logic        short_o
);

  localparam int PXW  = (BLKW  > 1) ? $clog2(BLKW)  : 1;
  localparam int COLW = (HBLKS > 1) ? $clog2(HBLKS) : 1;
  localparam int LNW  = (BLKH  > 1) ? $clog2(BLKH)  : 1;
  localparam int ROWW = (VBLKS > 1) ? $clog2(VBLKS) : 1;

  typedef enum logic [1:0] {WAIT_VS, WAIT_DE, LINE, DONE} state_t;

  state_t            state_q, state_d;
  logic [PXW-1:0]    px_q, px_d;
  logic [COLW-1:0]   col_q, col_d;
  logic [LNW-1:0]    ln_q, ln_d;
  logic [ROWW-1:0]   row_q, row_d;
  logic              full_q, full_d;
  logic              vs_prev_q;
  logic              de_q, de_d;
  logic              h_save_q, h_save_d;
  logic              v_save_q, v_save_d;
  logic              short_q, short_d;
  logic [23:0]       wd_q;
  logic              vs_edge;
  logic              take_px;

  assign vs_edge = vs_i & ~vs_prev_q;
  assign take_px = de_i && ((state_q == WAIT_DE) || (state_q == LINE));

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    col_d    = col_q;
    ln_d     = ln_q;
    row_d    = row_q;
    full_d   = full_q;
    de_d     = 1'b0;
    h_save_d = 1'b0;
    v_save_d = 1'b0;
    short_d  = short_q;

    if (vs_edge) begin
      // A vs edge always wins, even over a simultaneous de_i sample.
      if ((state_q != WAIT_VS) && ((row_q != '0) || (ln_q != '0)))
        short_d = 1'b1;
      state_d = WAIT_DE;
      px_d    = '0;
      col_d   = '0;
      ln_d    = '0;
      row_d   = '0;
      full_d  = 1'b0;
    end else if (take_px) begin
      state_d = LINE;
      if (!full_q) begin
        de_d = 1'b1;
        if (px_q == PXW'(BLKW - 1)) begin
          h_save_d = 1'b1;
          px_d     = '0;
          if (col_q == COLW'(HBLKS - 1))
            full_d = 1'b1;
          else
            col_d = col_q + COLW'(1);
        end else begin
          px_d = px_q + PXW'(1);
        end
      end
    end else if (state_q == LINE) begin
      // Falling de_i ends the line.
      if (!full_q)
        short_d = 1'b1;
      px_d    = '0;
      col_d   = '0;
      full_d  = 1'b0;
      state_d = WAIT_DE;
      if (ln_q == LNW'(BLKH - 1)) begin
        ln_d     = '0;
        v_save_d = 1'b1;
        if (row_q == ROWW'(VBLKS - 1)) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d = row_q + ROWW'(1);
        end
      end else begin
        ln_d = ln_q + LNW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WAIT_VS;
      px_q      <= '0;
      col_q     <= '0;
      ln_q      <= '0;
      row_q     <= '0;
      full_q    <= 1'b0;
      vs_prev_q <= 1'b1;
      de_q      <= 1'b0;
      h_save_q  <= 1'b0;
      v_save_q  <= 1'b0;
      short_q   <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      col_q     <= col_d;
      ln_q      <= ln_d;
      row_q     <= row_d;
      full_q    <= full_d;
      vs_prev_q <= vs_i;
      de_q      <= de_d;
      h_save_q  <= h_save_d;
      v_save_q  <= v_save_d;
      short_q   <= short_d;
      wd_q      <= rgb_i;
    end
  end

  assign de_o     = de_q;
  assign wd_o     = wd_q;
  assign h_save_o = h_save_q;
  assign v_save_o = v_save_q;
  assign short_o  = short_q;

endmodule

// File: tb/tb_blk_sync.sv
// Directed bench for blk_sync with a 2x2 grid of 3x2 blocks (6 pixels x 4 lines).
module tb_blk_sync;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        vs_i  = 1'b1;
  logic        de_i  = 1'b0;
  logic [23:0] rgb_i = '0;
  logic        de_o;
  logic [23:0] wd_o;
  logic        h_save_o;
  logic        v_save_o;
  logic        short_o;

  int errors = 0;
  int checks = 0;
  int de_cnt = 0;

  blk_sync #(.HBLKS(2), .VBLKS(2), .BLKW(3), .BLKH(2)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .vs_i    (vs_i),
    .de_i    (de_i),
    .rgb_i   (rgb_i),
    .de_o    (de_o),
    .wd_o    (wd_o),
    .h_save_o(h_save_o),
    .v_save_o(v_save_o),
    .short_o (short_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic vs, input logic de, input logic rs, input logic [23:0] rgb);
    @(negedge clk_i);
    vs_i  = vs;
    de_i  = de;
    rst_i = rs;
    rgb_i = rgb;
    @(posedge clk_i);
    #1;
  endtask

  task automatic vs_pulse();
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("vs_hi_de", {31'd0, de_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // n de cycles; inside an active frame pixels 0..5 are in window, saves at 2 and 5.
  task automatic do_line(input int n, input bit act, input bit vexp);
    logic [23:0] rgb;
    for (int i = 0; i < n; i++) begin
      rgb = 24'($urandom);
      step(1'b0, 1'b1, 1'b0, rgb);
      $display("line px=%0d de_o=%0b h_save_o=%0b wd_o=%06h", i, de_o, h_save_o, wd_o);
      chk("de_o", {31'd0, de_o}, {31'd0, act && (i < 6)});
      chk("h_save_o", {31'd0, h_save_o}, {31'd0, act && (i < 6) && (i % 3 == 2)});
      chk("wd_o", {8'd0, wd_o}, {8'd0, rgb});
      chk("v_in_line", {31'd0, v_save_o}, 32'd0);
      if (de_o) de_cnt++;
    end
    step(1'b0, 1'b0, 1'b0, 24'h0);
    $display("line end v_save_o=%0b short_o=%0b", v_save_o, short_o);
    chk("v_save_o", {31'd0, v_save_o}, {31'd0, vexp});
    chk("de_idle", {31'd0, de_o}, 32'd0);
  endtask

  initial begin
    // Reset with vs held high: no edge must be seen on release.
    step(1'b1, 1'b0, 1'b1, 24'h123456);
    step(1'b1, 1'b0, 1'b1, 24'h123456);
    chk("rst_de", {31'd0, de_o}, 32'd0);
    chk("rst_wd", {8'd0, wd_o}, 32'd0);
    chk("rst_short", {31'd0, short_o}, 32'd0);
    chk("rst_h", {31'd0, h_save_o}, 32'd0);
    chk("rst_v", {31'd0, v_save_o}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    chk("no_edge_de", {31'd0, de_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 24'h0);

    // Normal frame of 6-pixel lines.
    vs_pulse();
    de_cnt = 0;
    for (int l = 0; l < 4; l++) do_line(6, 1'b1, l % 2 == 1);
    chk("de_count", de_cnt, 32'd24);
    chk("short_normal", {31'd0, short_o}, 32'd0);

    // Extra lines after the frame are masked.
    do_line(6, 1'b0, 1'b0);
    do_line(6, 1'b0, 1'b0);

    // Over-long lines: pixels 6 and 7 masked.
    vs_pulse();
    de_cnt = 0;
    for (int l = 0; l < 4; l++) do_line(8, 1'b1, l % 2 == 1);
    chk("de_count_long", de_cnt, 32'd24);
    chk("short_long", {31'd0, short_o}, 32'd0);

    // Short first line.
    vs_pulse();
    do_line(4, 1'b1, 1'b0);
    chk("short_line", {31'd0, short_o}, 32'd1);
    for (int l = 1; l < 4; l++) do_line(6, 1'b1, l % 2 == 1);

    // Reset mid-line.
    vs_pulse();
    step(1'b0, 1'b1, 1'b0, 24'hAAAAAA);
    step(1'b0, 1'b1, 1'b0, 24'hBBBBBB);
    chk("pre_rst_de", {31'd0, de_o}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 24'hCCCCCC);
    chk("mid_rst_de", {31'd0, de_o}, 32'd0);
    chk("mid_rst_wd", {8'd0, wd_o}, 32'd0);
    chk("mid_rst_h", {31'd0, h_save_o}, 32'd0);
    chk("mid_rst_v", {31'd0, v_save_o}, 32'd0);
    chk("mid_rst_short", {31'd0, short_o}, 32'd0);
    do_line(6, 1'b0, 1'b0);

    // Frame aborted after 1.5 block rows, vs edge together with de.
    vs_pulse();
    do_line(6, 1'b1, 1'b0);
    do_line(6, 1'b1, 1'b1);
    do_line(6, 1'b1, 1'b0);
    chk("short_pre_abort", {31'd0, short_o}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 24'h5A5A5A);
    chk("abort_de", {31'd0, de_o}, 32'd0);
    chk("abort_v", {31'd0, v_save_o}, 32'd0);
    chk("abort_h", {31'd0, h_save_o}, 32'd0);
    chk("abort_short", {31'd0, short_o}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    chk("abort_nov", {31'd0, v_save_o}, 32'd0);
    de_cnt = 0;
    for (int l = 0; l < 4; l++) do_line(6, 1'b1, l % 2 == 1);
    chk("de_count_restart", de_cnt, 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
